spi_mem_loader: RTL and testbench
=================================

Name: spi_mem_loader

Overview:
- Parametrised SPI-slave-to-memory bridge: successor to the fixed 8-bit SPI-into-SPRAM capture path.
- Oversamples an external SPI link (mode 0, MSB first) on the system clock and assembles DATA_W-bit words.
- Each frame starts with a header word that selects write or read, followed by payload words.
- Writes stream into a single-port synchronous RAM at auto-incrementing addresses; reads stream RAM contents back out on sdo.

Parameters:
- DATA_W, 8, bits per SPI word and RAM word width (4..32).
- DEPTH, 16384, RAM words; ADDR_W = $clog2(DEPTH).
- WRAP, 1, 1 = address wraps DEPTH-1 -> 0; 0 = saturate at DEPTH-1 and raise ovf.
- SYNC_STAGES, 2, synchroniser flops on sck/sdi/load.

Ports:
- clk  in  1  system clock; must run at least 4x sck.
- reset_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock, asynchronous to clk.
- sdi  in  1  SPI data in.
- load  in  1  frame enable, active high (acts as chip select).
- sdo  out  1  SPI data out.
- mem_we  out  1  RAM write strobe, one clk wide.
- mem_re  out  1  RAM read strobe, one clk wide.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 clk after mem_re.
- word_count  out  ADDR_W+1  payload words in the current/last frame.
- frame_done  out  1  one-clk pulse when load falls.
- ovf  out  1  sticky; saturate-mode address overrun; cleared at frame start.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, address 0, shift registers 0.
- Synchronisation: sck, sdi, load each pass through SYNC_STAGES flops.
  - sck rise/fall events come from edge-detecting the synchronised sck.
  - sdi is sampled on the sck-rise event; sdo updates on the sck-fall event.
- FSM states: IDLE, HEADER, WRITE, READ.
  - IDLE -> HEADER on load rise: clear bit counter, mem_addr, word_count and ovf.
  - HEADER: after DATA_W bits, header[DATA_W-1] = 1 -> READ, else WRITE.
  - HEADER: header[DATA_W-2:0] is reserved and ignored.
  - On entry to READ, issue mem_re at address 0.
  - Any state -> IDLE on load fall: pulse frame_done the same cycle.
  - A partial word is discarded on load fall; no write is issued for it.
- WRITE:
  - On each DATA_W-th sck rise, assert mem_we for one clk with mem_wdata = assembled word.
  - The following clk: mem_addr advances and word_count increments.
- READ:
  - The word returned by mem_re is loaded into the out shifter one clk later; its MSB drives sdo.
  - Remaining bits shift on sck falls.
  - On the last fall of a word: mem_addr advances, word_count increments, and the next mem_re issues immediately so data is ready before the next MSB.
  - sdo = 0 outside READ.
- Address end, WRAP=1: DEPTH-1 -> 0, silently.
- Address end, WRAP=0: mem_addr holds DEPTH-1 and ovf sets.
  - Further writes are suppressed (mem_we stays 0).
  - Further reads repeat the last word.
- word_count saturates at all-ones.
- load rise and fall within one clk: treated as a glitch, no state change.
- reset_n low mid-frame: everything returns immediately to reset values; no strobe is emitted.

Decomposition:
- Package spi_mem_pkg: state enum typedef (IDLE, HEADER, WRITE, READ) and header bit index constant HDR_RW.
- One natural sub-module, spi_edge_sync: synchroniser plus rise/fall pulse generation for sck and load, and synchronised sdi; parametrised by SYNC_STAGES.
- Word shift registers and FSM stay in the top.

Test Plan:
- Write frame, DATA_W=8: header 0x00 then 0xA5, 0x3C -> mem_we at addr 0 with 0xA5 and addr 1 with 0x3C; word_count=2; frame_done one pulse.
- Read frame: RAM model preloaded addr0=0x5A, addr1=0xC3; header 0x80 then 16 sck -> sdo bit stream 01011010 11000011 MSB first; mem_re at addrs 0,1,2.
- Partial word: header 0x00, then 0x11, then 5 bits, then load falls -> exactly one mem_we (0x11); word_count=1.
- Wrap with DEPTH=4, WRAP=1: 5 payload words -> addrs 0,1,2,3,0; ovf stays 0.
- Saturate with DEPTH=4, WRAP=0: 5 payload words -> 4 writes, ovf=1.
  - ovf clears on the next load rise.
- reset_n pulled low mid-word during a write frame -> no mem_we, outputs return to 0; the next frame behaves normally from addr 0.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared types for the SPI-to-memory loader: frame FSM states and header layout.
package spi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        WRITE,
        READ
    } state_t;

    // R/W flag position counted down from the header width: bit DATA_W-HDR_RW (the MSB)
    localparam int HDR_RW = 1;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the SPI pins into clk and derives one-clk edge pulses for sck and load.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sck,
    input  logic sdi,
    input  logic load,
    output logic sck_rise,
    output logic sck_fall,
    output logic load_rise,
    output logic load_fall,
    output logic sdi_s
);

    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] sdi_sr;
    logic [SYNC_STAGES-1:0] load_sr;
    logic                   sck_d;
    logic                   load_p;
    logic                   load_f;
    logic                   load_fd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sr  <= '0;
            sdi_sr  <= '0;
            load_sr <= '0;
            sck_d   <= 1'b0;
            load_p  <= 1'b0;
            load_f  <= 1'b0;
            load_fd <= 1'b0;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
            sdi_sr  <= {sdi_sr[SYNC_STAGES-2:0], sdi};
            load_sr <= {load_sr[SYNC_STAGES-2:0], load};
            sck_d   <= sck_sr[SYNC_STAGES-1];
            load_p  <= load_sr[SYNC_STAGES-1];
            // load must hold for two samples before it counts, so a one-clk blip never opens a frame
            if (load_sr[SYNC_STAGES-1] == load_p)
                load_f <= load_p;
            load_fd <= load_f;
        end
    end

    assign sck_rise  =  sck_sr[SYNC_STAGES-1] & ~sck_d;
    assign sck_fall  = ~sck_sr[SYNC_STAGES-1] &  sck_d;
    assign load_rise =  load_f & ~load_fd;
    assign load_fall = ~load_f &  load_fd;
    assign sdi_s     =  sdi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_loader.sv
// SPI-slave (mode 0, MSB first) bridge streaming framed words into or out of a
// single-port synchronous RAM at auto-incrementing addresses.
module spi_mem_loader
    import spi_mem_pkg::*;
#(
    parameter int  DATA_W      = 8,
    parameter int  DEPTH       = 16384,
    parameter int  WRAP        = 1,
    parameter int  SYNC_STAGES = 2,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sck,
    input  logic              sdi,
    input  logic              load,
    output logic              sdo,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   word_count,
    output logic              frame_done,
    output logic              ovf
);

    localparam int                CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state, state_n;
    logic                sck_rise, sck_fall, load_rise, load_fall, sdi_s;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shin, shout, word_in;
    logic                adv, re_d, skip, full;
    logic                word_done, rd_last, addr_last;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [ADDR_W:0]     wc_nxt;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .sck      (sck),
        .sdi      (sdi),
        .load     (load),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .load_rise(load_rise),
        .load_fall(load_fall),
        .sdi_s    (sdi_s)
    );

    assign word_in   = {shin[DATA_W-2:0], sdi_s};
    assign word_done = sck_rise && (bit_cnt == LAST_BIT);
    assign rd_last   = (state == READ) && sck_fall && !skip && (bit_cnt == LAST_BIT);
    assign addr_last = (mem_addr == LAST_ADDR);
    assign addr_nxt  = addr_last ? ((WRAP != 0) ? '0 : mem_addr) : mem_addr + 1'b1;
    assign wc_nxt    = (&word_count) ? word_count : word_count + 1'b1;

    assign sdo        = (state == READ) ? shout[DATA_W-1] : 1'b0;
    assign frame_done = load_fall && (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (load_rise) state_n = HEADER;
            HEADER:  if (word_done) state_n = word_in[DATA_W-HDR_RW] ? READ : WRITE;
            default: ;
        endcase
        if (load_fall) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            shin       <= '0;
            shout      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            re_d       <= 1'b0;
            adv        <= 1'b0;
            skip       <= 1'b0;
            full       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            re_d   <= mem_re;
            adv    <= 1'b0;
            if (re_d)
                shout <= mem_rdata;
            if (adv || rd_last) begin
                mem_addr   <= addr_nxt;
                word_count <= wc_nxt;
                if (addr_last && WRAP == 0)
                    full <= 1'b1;
            end
            case (state)
                IDLE: if (load_rise) begin
                    bit_cnt    <= '0;
                    shin       <= '0;
                    mem_addr   <= '0;
                    word_count <= '0;
                    ovf        <= 1'b0;
                    full       <= 1'b0;
                    skip       <= 1'b0;
                end
                HEADER, WRITE: if (sck_rise) begin
                    shin <= word_in;
                    if (word_done) bit_cnt <= '0;
                    else           bit_cnt <= bit_cnt + 1'b1;
                    // trailing header fall arrives before read data is loaded; skip it
                    if (word_done && state == HEADER && word_in[DATA_W-HDR_RW]) begin
                        mem_re <= 1'b1;
                        skip   <= 1'b1;
                    end
                    if (word_done && state == WRITE) begin
                        adv <= 1'b1;
                        if (full) begin
                            ovf <= 1'b1;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_wdata <= word_in;
                        end
                    end
                end
                READ: if (sck_fall) begin
                    if (skip) begin
                        skip <= 1'b0;
                    end else if (rd_last) begin
                        bit_cnt <= '0;
                        mem_re  <= 1'b1;
                        if (full) ovf <= 1'b1;
                    end else begin
                        shout   <= {shout[DATA_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (load_fall) begin
                bit_cnt <= '0;
                shin    <= '0;
                shout   <= '0;
                skip    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_loader.sv
// Directed bench for spi_mem_loader: default, wrapping and saturating instances share one SPI bus.
module tb_spi_mem_loader;

    logic clk = 1'b0, reset_n = 1'b0, sck = 1'b0, sdi = 1'b0, load = 1'b0;
    always #5 clk = ~clk;

    logic m_sdo, m_we, m_re, m_fd, m_ovf;
    logic [13:0] m_addr;
    logic [7:0]  m_wdata, m_rdata = 8'h00;
    logic [14:0] m_wc;
    logic w_sdo, w_we, w_re, w_fd, w_ovf;
    logic [1:0]  w_addr;
    logic [7:0]  w_wdata, w_rdata = 8'h00;
    logic [2:0]  w_wc;
    logic s_sdo, s_we, s_re, s_fd, s_ovf;
    logic [1:0]  s_addr;
    logic [7:0]  s_wdata, s_rdata = 8'h00;
    logic [2:0]  s_wc;

    spi_mem_loader #(.DATA_W(8), .DEPTH(16384), .WRAP(1), .SYNC_STAGES(2)) u_main (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load), .sdo(m_sdo),
        .mem_we(m_we), .mem_re(m_re), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_rdata(m_rdata), .word_count(m_wc), .frame_done(m_fd), .ovf(m_ovf));
    spi_mem_loader #(.DATA_W(8), .DEPTH(4), .WRAP(1), .SYNC_STAGES(2)) u_wrap (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load), .sdo(w_sdo),
        .mem_we(w_we), .mem_re(w_re), .mem_addr(w_addr), .mem_wdata(w_wdata),
        .mem_rdata(w_rdata), .word_count(w_wc), .frame_done(w_fd), .ovf(w_ovf));
    spi_mem_loader #(.DATA_W(8), .DEPTH(4), .WRAP(0), .SYNC_STAGES(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load), .sdo(s_sdo),
        .mem_we(s_we), .mem_re(s_re), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .mem_rdata(s_rdata), .word_count(s_wc), .frame_done(s_fd), .ovf(s_ovf));

    // RAM models plus logs of every strobe seen
    logic [7:0] m_mem [16384];
    logic [7:0] w_mem [4];
    logic [7:0] s_mem [4];
    int m_wa[$], m_ra[$], w_wa[$], s_wa[$];
    logic [7:0] m_wd[$], w_wd[$], s_wd[$];
    int m_fdn = 0;

    always @(posedge clk) begin
        if (m_we) begin m_mem[m_addr] <= m_wdata; m_wa.push_back(int'(m_addr)); m_wd.push_back(m_wdata); end
        if (m_re) begin m_rdata <= m_mem[m_addr]; m_ra.push_back(int'(m_addr)); end
        if (w_we) begin w_mem[w_addr] <= w_wdata; w_wa.push_back(int'(w_addr)); w_wd.push_back(w_wdata); end
        if (w_re) w_rdata <= w_mem[w_addr];
        if (s_we) begin s_mem[s_addr] <= s_wdata; s_wa.push_back(int'(s_addr)); s_wd.push_back(s_wdata); end
        if (s_re) s_rdata <= s_mem[s_addr];
        if (m_fd) m_fdn++;
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic so);
        sdi = b;
        repeat (8) @(negedge clk);
        so  = m_sdo;
        sck = 1'b1;
        repeat (8) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int nbits);
        logic so;
        for (int b = 0; b < nbits; b++) spi_bit(w[7-b], so);
    endtask

    task automatic frame_start();
        load = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (6) @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  hdr;
        int          nw;
        logic [31:0] words;   // first payload word in [31:24]
        int          nbits;   // trailing partial-word bits
        logic [7:0]  part;
        int          exp_w;
        int          exp_wc;
    } wvec_t;

    wvec_t vecs[4];
    int    fd0;
    logic  so;
    logic [15:0] rx;
    int wrap_a[5];
    logic [7:0] pay[5];

    initial begin
        vecs[0] = '{8'h00, 2, 32'hA53C_0000, 0, 8'h00, 2, 2};
        vecs[1] = '{8'h00, 1, 32'h1100_0000, 5, 8'hF8, 1, 1};
        vecs[2] = '{8'h7F, 3, 32'hFF00_8100, 0, 8'h00, 3, 3};
        vecs[3] = '{8'h00, 0, 32'h0000_0000, 3, 8'hE0, 0, 0};
        wrap_a  = '{0, 1, 2, 3, 0};
        pay     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        repeat (3) @(negedge clk);
        check("reset outputs", {m_sdo, m_we, m_re, m_addr, m_wdata, m_wc, m_fd, m_ovf}, 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // write frames from the table
        for (int i = 0; i < 4; i++) begin
            m_wa.delete(); m_wd.delete();
            fd0 = m_fdn;
            frame_start();
            send_word(vecs[i].hdr, 8);
            for (int j = 0; j < vecs[i].nw; j++) send_word(vecs[i].words[31-8*j -: 8], 8);
            if (vecs[i].nbits > 0) send_word(vecs[i].part, vecs[i].nbits);
            frame_end();
            check($sformatf("v%0d write count", i), m_wa.size(), vecs[i].exp_w);
            for (int j = 0; j < vecs[i].exp_w; j++) begin
                check($sformatf("v%0d wr%0d addr", i, j), (j < m_wa.size()) ? m_wa[j] : -1, j);
                check($sformatf("v%0d wr%0d data", i, j), (j < m_wd.size()) ? m_wd[j] : 8'hXX,
                      vecs[i].words[31-8*j -: 8]);
            end
            check($sformatf("v%0d word_count", i), m_wc, vecs[i].exp_wc);
            check($sformatf("v%0d end addr", i), m_addr, vecs[i].exp_w);
            check($sformatf("v%0d frame_done pulses", i), m_fdn - fd0, 1);
            check($sformatf("v%0d ovf", i), m_ovf, 0);
        end

        // read frame
        m_mem[0] = 8'h5A; m_mem[1] = 8'hC3;
        m_ra.delete();
        frame_start();
        send_word(8'h80, 8);
        rx = '0;
        for (int b = 0; b < 16; b++) begin
            spi_bit(1'b0, so);
            rx = {rx[14:0], so};
        end
        frame_end();
        check("rd sdo stream", rx, 16'h5AC3);
        check("rd re count", m_ra.size(), 3);
        for (int j = 0; j < 3; j++)
            check($sformatf("rd re%0d addr", j), (j < m_ra.size()) ? m_ra[j] : -1, j);
        check("rd word_count", m_wc, 2);
        check("rd sdo idle", m_sdo, 0);

        // one-clk load blip must not restart a frame
        fd0 = m_fdn;
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch word_count", m_wc, 2);
        check("glitch frame_done", m_fdn - fd0, 0);

        // wrap vs saturate on DEPTH=4
        w_wa.delete(); w_wd.delete(); s_wa.delete(); s_wd.delete();
        frame_start();
        send_word(8'h00, 8);
        for (int j = 0; j < 5; j++) send_word(pay[j], 8);
        frame_end();
        check("wrap write count", w_wa.size(), 5);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("wrap wr%0d addr", j), (j < w_wa.size()) ? w_wa[j] : -1, wrap_a[j]);
            check($sformatf("wrap wr%0d data", j), (j < w_wd.size()) ? w_wd[j] : 8'hXX, pay[j]);
        end
        check("wrap ovf", w_ovf, 0);
        check("wrap word_count", w_wc, 5);
        check("sat write count", s_wa.size(), 4);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("sat wr%0d addr", j), (j < s_wa.size()) ? s_wa[j] : -1, j);
            check($sformatf("sat wr%0d data", j), (j < s_wd.size()) ? s_wd[j] : 8'hXX, pay[j]);
        end
        check("sat ovf", s_ovf, 1);
        check("sat addr hold", s_addr, 3);
        frame_start();
        check("sat ovf cleared", s_ovf, 0);
        frame_end();

        // reset mid-word inside a write frame
        frame_start();
        send_word(8'h00, 8);
        send_word(8'h99, 8);
        repeat (4) @(negedge clk);
        m_wa.delete(); m_wd.delete();
        send_word(8'hE0, 3);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid reset outputs", {m_sdo, m_we, m_re, m_addr, m_wdata, m_wc, m_fd, m_ovf}, 32'h0);
        load = 1'b0; sck = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mid reset no write", m_wa.size(), 0);
        frame_start();
        send_word(8'h00, 8);
        send_word(8'h77, 8);
        frame_end();
        check("post reset count", m_wa.size(), 1);
        check("post reset addr", (m_wa.size() > 0) ? m_wa[0] : -1, 0);
        check("post reset data", (m_wd.size() > 0) ? m_wd[0] : 8'hXX, 8'h77);
        check("post reset word_count", m_wc, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, tests run %0d", tests);
        $fatal(1);
    end

endmodule
